// File: rtl/sha256_sched_ctrl_if.sv
// Handshake bundle between the block source, the SHA-256 message
// schedule controller and the compression datapath that consumes rounds.
interface sha256_sched_ctrl_if #(
  parameter int IN_W = 512
);
  logic            blk_valid;
  logic [IN_W-1:0] blk_data;
  logic            blk_ready;
  logic            rnd_valid;
  logic            rnd_ready;
  logic [5:0]      rnd_idx;
  logic [31:0]     rnd_w;
  logic            rnd_first;
  logic            rnd_last;
  logic            blk_done;
  logic            abort;

  // Controller side: takes blocks in, hands schedule words out.
  modport slave (
    input  blk_valid, blk_data, rnd_ready, abort,
    output blk_ready, rnd_valid, rnd_idx, rnd_w, rnd_first, rnd_last, blk_done
  );

  // Environment side: supplies blocks and consumes rounds.
  modport master (
    output blk_valid, blk_data, rnd_ready, abort,
    input  blk_ready, rnd_valid, rnd_idx, rnd_w, rnd_first, rnd_last, blk_done
  );
endinterface

// File: rtl/sha256_sched_ctrl.sv
// SHA-256 message schedule controller.
// Captures a 512-bit block, then streams W_0..W_63 one round per handshake.
// W_0..W_15 come straight from the captured block; W_16..W_63 are expanded
// on the fly from a 16-entry ring of previously issued words, so each word
// is available combinationally in the same cycle its round is presented.
module sha256_sched_ctrl #(
  parameter int IN_W   = 512,
  parameter int ROUNDS = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  sha256_sched_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  logic [1:0]      state_q, state_d;
  logic [5:0]      t_q, t_d;
  logic [IN_W-1:0] block_q, block_d;
  logic [31:0]     ring_q [16];

  logic            blkFire;
  logic            rndFire;
  logic [3:0]      slotCur;
  logic [3:0]      slotM15;
  logic [3:0]      slotM7;
  logic [3:0]      slotM2;
  logic [31:0]     blockWord;
  logic [31:0]     expandedWord;
  logic [31:0]     schedW;

  function automatic logic [31:0] smallSigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] smallSigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // Ring slots of W[t-16], W[t-15], W[t-7] and W[t-2]; the 4-bit adds wrap.
  // W[t-16] lives in the same slot that W[t] is about to overwrite.
  assign slotCur = t_q[3:0];
  assign slotM15 = t_q[3:0] + 4'd1;
  assign slotM7  = t_q[3:0] + 4'd9;
  assign slotM2  = t_q[3:0] + 4'd14;

  assign blockWord    = block_q[{t_q[3:0], 5'b00000} +: 32];
  assign expandedWord = ring_q[slotCur] + smallSigma0(ring_q[slotM15])
                      + ring_q[slotM7]  + smallSigma1(ring_q[slotM2]);
  assign schedW       = (t_q[5:4] == 2'b00) ? blockWord : expandedWord;

  // Ready is forced low while reset is held so nothing is accepted then.
  assign bus.blk_ready = rst_n && ((state_q == IDLE) || (state_q == DONE));
  assign bus.rnd_valid = (state_q == RUN);
  assign bus.rnd_idx   = bus.rnd_valid ? t_q : 6'd0;
  assign bus.rnd_w     = bus.rnd_valid ? schedW : 32'd0;
  assign bus.rnd_first = bus.rnd_valid && (t_q == 6'd0);
  assign bus.rnd_last  = bus.rnd_valid && (t_q == LAST_ROUND);
  assign bus.blk_done  = (state_q == DONE);

  assign blkFire = bus.blk_valid && bus.blk_ready;
  assign rndFire = bus.rnd_valid && bus.rnd_ready;

  // Next-state logic; abort outranks both the block and the round handshake.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    block_d = block_q;
    if (bus.abort) begin
      state_d = IDLE;
      t_d     = 6'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (blkFire) begin
            block_d = bus.blk_data;
            t_d     = 6'd0;
            state_d = RUN;
          end
        end
        RUN: begin
          if (rndFire) begin
            if (t_q == LAST_ROUND) begin
              t_d     = 6'd0;
              state_d = DONE;
            end else begin
              t_d = t_q + 6'd1;
            end
          end
        end
        DONE: begin
          if (blkFire) begin
            block_d = bus.blk_data;
            t_d     = 6'd0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          t_d     = 6'd0;
        end
      endcase
    end
  end

  // Control state and captured block, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= 6'd0;
      block_q <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      block_q <= block_d;
    end
  end

  // Ring of issued words; no reset needed since slots 0..15 are rewritten
  // by rounds 0..15 of every block before any expansion reads them.
  always_ff @(posedge clk) begin
    if (rndFire && !bus.abort) begin
      ring_q[slotCur] <= schedW;
    end
  end

endmodule

// File: tb/tb_sha256_sched_ctrl.sv
// Directed bench for the SHA-256 schedule controller: "abc" block with and
// without stalls, back-to-back blocks, abort, mid-run reset, and a stray
// blk_valid pulse during a run.
module tb_sha256_sched_ctrl;

   logic clk = 1'b0;
   logic rst_n;

   int testCount = 0;
   int failCount = 0;

   logic [31:0]  model [64];
   logic [31:0]  seenW [64];
   logic [511:0] abcBlk;
   logic [511:0] blkB;
   logic [511:0] blkC;
   int           cycles;

   sha256_sched_ctrl_if #(.IN_W(512)) bus ();

   sha256_sched_ctrl #(.IN_W(512), .ROUNDS(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Straightforward array form of the SHA-256 message expansion.
   task automatic computeModel(input logic [511:0] b);
      for (int t = 0; t < 64; t++) begin
         if (t < 16) begin
            model[t] = b[t*32 +: 32];
         end else begin
            model[t] = model[t-16]
                     + (rotr(model[t-15], 7) ^ rotr(model[t-15], 18) ^ (model[t-15] >> 3))
                     + model[t-7]
                     + (rotr(model[t-2], 17) ^ rotr(model[t-2], 19) ^ (model[t-2] >> 10));
         end
      end
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [511:0] d, input logic rr, input logic ab);
      bus.blk_valid = v;
      bus.blk_data  = d;
      bus.rnd_ready = rr;
      bus.abort     = ab;
   endtask

   // Present a block for one edge and check that it was offered while ready.
   task automatic acceptBlock(input string tag, input logic [511:0] d);
      applyStimulus(1'b1, d, 1'b0, 1'b0);
      checkOutput({tag, " blk_ready before accept"}, 64'(bus.blk_ready), 64'd1);
      tick();
   endtask

   // Walk one block's rounds. validMode 0: leave blk_valid alone, 2: pulse it
   // at round 5. stopKind 1 aborts at round stopAt, 2 resets at round stopAt.
   task automatic runBlock(input string tag, input bit randomStall, input int validMode,
                           input int stopAt, input int stopKind, output int nCycles);
      int          expIdx;
      int          firsts;
      int          lasts;
      bit          stalled;
      bit          stopped;
      bit          rr;
      logic [5:0]  prevIdx;
      logic [31:0] prevW;
      expIdx  = 0;
      firsts  = 0;
      lasts   = 0;
      stalled = 1'b0;
      stopped = 1'b0;
      prevIdx = '0;
      prevW   = '0;
      nCycles = 0;
      while (expIdx < 64 && nCycles < 1000 && !stopped) begin
         checkOutput($sformatf("%s rnd_valid t=%0d", tag, expIdx), 64'(bus.rnd_valid), 64'd1);
         checkOutput($sformatf("%s blk_ready t=%0d", tag, expIdx), 64'(bus.blk_ready), 64'd0);
         if (stalled) begin
            checkOutput($sformatf("%s hold idx t=%0d", tag, expIdx), 64'(bus.rnd_idx), 64'(prevIdx));
            checkOutput($sformatf("%s hold w t=%0d", tag, expIdx), 64'(bus.rnd_w), 64'(prevW));
         end
         checkOutput($sformatf("%s rnd_idx t=%0d", tag, expIdx), 64'(bus.rnd_idx), 64'(expIdx));
         checkOutput($sformatf("%s rnd_w t=%0d", tag, expIdx), 64'(bus.rnd_w), 64'(model[expIdx]));
         checkOutput($sformatf("%s rnd_first t=%0d", tag, expIdx), 64'(bus.rnd_first), 64'(expIdx == 0));
         checkOutput($sformatf("%s rnd_last t=%0d", tag, expIdx), 64'(bus.rnd_last), 64'(expIdx == 63));
         prevIdx = bus.rnd_idx;
         prevW   = bus.rnd_w;
         if (expIdx == stopAt && stopKind == 1) begin
            bus.abort     = 1'b1;
            bus.rnd_ready = 1'b1;
            tick();
            bus.abort     = 1'b0;
            bus.rnd_ready = 1'b0;
            stopped       = 1'b1;
         end else if (expIdx == stopAt && stopKind == 2) begin
            rst_n = 1'b0;
            #1;
            checkOutput({tag, " reset rnd_valid"}, 64'(bus.rnd_valid), 64'd0);
            checkOutput({tag, " reset rnd_first"}, 64'(bus.rnd_first), 64'd0);
            checkOutput({tag, " reset rnd_last"}, 64'(bus.rnd_last), 64'd0);
            checkOutput({tag, " reset blk_done"}, 64'(bus.blk_done), 64'd0);
            checkOutput({tag, " reset rnd_idx"}, 64'(bus.rnd_idx), 64'd0);
            checkOutput({tag, " reset rnd_w"}, 64'(bus.rnd_w), 64'd0);
            checkOutput({tag, " reset blk_ready"}, 64'(bus.blk_ready), 64'd0);
            tick();
            tick();
            @(negedge clk);
            rst_n = 1'b1;
            tick();
            stopped = 1'b1;
         end else begin
            rr = randomStall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.rnd_ready = rr;
            if (validMode == 2) bus.blk_valid = (expIdx == 5);
            if (rr) begin
               seenW[expIdx] = bus.rnd_w;
               firsts += int'(bus.rnd_first);
               lasts  += int'(bus.rnd_last);
            end
            tick();
            nCycles++;
            if (rr) expIdx++;
            stalled = !rr;
         end
      end
      if (validMode == 2) bus.blk_valid = 1'b0;
      bus.rnd_ready = 1'b0;
      if (!stopped) begin
         checkOutput({tag, " all rounds consumed"}, 64'(expIdx), 64'd64);
         checkOutput({tag, " blk_done after round 63"}, 64'(bus.blk_done), 64'd1);
         checkOutput({tag, " rnd_valid dropped"}, 64'(bus.rnd_valid), 64'd0);
         checkOutput({tag, " blk_ready in DONE"}, 64'(bus.blk_ready), 64'd1);
         checkOutput({tag, " rnd_first count"}, 64'(firsts), 64'd1);
         checkOutput({tag, " rnd_last count"}, 64'(lasts), 64'd1);
      end
   endtask

   // Step back to IDLE after DONE with no new block offered.
   task automatic checkIdle(input string tag);
      tick();
      checkOutput({tag, " idle blk_done"}, 64'(bus.blk_done), 64'd0);
      checkOutput({tag, " idle blk_ready"}, 64'(bus.blk_ready), 64'd1);
      checkOutput({tag, " idle rnd_valid"}, 64'(bus.rnd_valid), 64'd0);
   endtask

   // Linear sequence of directed scenarios.
   initial begin
      abcBlk = '0;
      abcBlk[31:0]    = 32'h61626380;
      abcBlk[480 +: 32] = 32'h00000018;
      for (int t = 0; t < 16; t++) begin
         blkB[t*32 +: 32] = {8'(t + 1), 8'(t * 7), 8'hA5, 8'(255 - t)};
         blkC[t*32 +: 32] = 32'hDEADBEEF ^ 32'(32'h01010101 * t);
      end

      rst_n = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0);
      #2;
      checkOutput("por rnd_valid", 64'(bus.rnd_valid), 64'd0);
      checkOutput("por blk_ready", 64'(bus.blk_ready), 64'd0);
      checkOutput("por blk_done", 64'(bus.blk_done), 64'd0);
      checkOutput("por rnd_idx", 64'(bus.rnd_idx), 64'd0);
      checkOutput("por rnd_w", 64'(bus.rnd_w), 64'd0);
      checkOutput("por rnd_first", 64'(bus.rnd_first), 64'd0);
      checkOutput("por rnd_last", 64'(bus.rnd_last), 64'd0);
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checkOutput("post-reset blk_ready", 64'(bus.blk_ready), 64'd1);
      checkOutput("post-reset rnd_valid", 64'(bus.rnd_valid), 64'd0);

      $display("[TB] abc block, rnd_ready held high");
      computeModel(abcBlk);
      acceptBlock("abc", abcBlk);
      bus.blk_valid = 1'b0;
      runBlock("abc", 1'b0, 0, -1, 0, cycles);
      checkOutput("abc done latency", 64'(cycles + 1), 64'd65);
      checkOutput("abc W0", 64'(seenW[0]), 64'h61626380);
      checkOutput("abc W15", 64'(seenW[15]), 64'h00000018);
      checkOutput("abc W16", 64'(seenW[16]), 64'h61626380);
      checkOutput("abc W17", 64'(seenW[17]), 64'h000F0000);
      checkIdle("abc");

      $display("[TB] abc block, random rnd_ready stalls");
      acceptBlock("abcStall", abcBlk);
      bus.blk_valid = 1'b0;
      runBlock("abcStall", 1'b1, 0, -1, 0, cycles);
      checkIdle("abcStall");

      $display("[TB] back-to-back blocks with blk_valid held");
      acceptBlock("b2b first", abcBlk);
      bus.blk_data = blkB;
      runBlock("b2b first", 1'b0, 0, -1, 0, cycles);
      tick();
      bus.blk_valid = 1'b0;
      checkOutput("b2b rnd_first after done", 64'(bus.rnd_first), 64'd1);
      checkOutput("b2b rnd_valid after done", 64'(bus.rnd_valid), 64'd1);
      computeModel(blkB);
      runBlock("b2b second", 1'b0, 0, -1, 0, cycles);
      checkIdle("b2b");

      $display("[TB] abort at t=30 then a fresh block");
      acceptBlock("abort", blkB);
      bus.blk_valid = 1'b0;
      runBlock("abort", 1'b0, 0, 30, 1, cycles);
      checkOutput("abort rnd_valid", 64'(bus.rnd_valid), 64'd0);
      checkOutput("abort blk_done", 64'(bus.blk_done), 64'd0);
      checkOutput("abort blk_ready", 64'(bus.blk_ready), 64'd1);
      tick();
      checkOutput("abort no late blk_done", 64'(bus.blk_done), 64'd0);
      computeModel(blkC);
      acceptBlock("afterAbort", blkC);
      bus.blk_valid = 1'b0;
      runBlock("afterAbort", 1'b0, 0, -1, 0, cycles);
      checkIdle("afterAbort");

      $display("[TB] stray blk_valid pulse during RUN");
      computeModel(abcBlk);
      acceptBlock("pulse", abcBlk);
      bus.blk_valid = 1'b0;
      bus.blk_data  = blkB;
      runBlock("pulse", 1'b0, 2, -1, 0, cycles);
      checkIdle("pulse");

      $display("[TB] reset asserted at t=40");
      acceptBlock("rst", abcBlk);
      bus.blk_valid = 1'b0;
      runBlock("rst", 1'b0, 0, 40, 2, cycles);
      checkOutput("rst release blk_ready", 64'(bus.blk_ready), 64'd1);
      checkOutput("rst release rnd_valid", 64'(bus.rnd_valid), 64'd0);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("rst no blk_done %0d", i), 64'(bus.blk_done), 64'd0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/sha256_sched_ctrl.md
SHA256_SCHED_CTRL -- requirements
Module: sha256_sched_ctrl

Interface
REQ-001 SHALL have parameter IN_W, default 512, message block width in bits; only 512 is supported.
REQ-002 SHALL have parameter ROUNDS, default 64, rounds per block; only 64 is supported.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port blk_valid, input, 1, the upstream block on blk_data is valid.
REQ-006 SHALL have port blk_data, input, IN_W, the message block; word t (t=0..15) = blk_data[t*32 +: 32].
REQ-007 SHALL have port blk_ready, output, 1, the block can be accepted this cycle.
REQ-008 SHALL have port rnd_valid, output, 1, rnd_w and rnd_idx are valid for one round.
REQ-009 SHALL have port rnd_ready, input, 1, the compression datapath consumes the current round.
REQ-010 SHALL have port rnd_idx, output, 6, the current round number t, used as the K-table index.
REQ-011 SHALL have port rnd_w, output, 32, the message schedule word W_t.
REQ-012 SHALL have port rnd_first, output, 1, high when t=0 and rnd_valid is high.
REQ-013 SHALL have port rnd_last, output, 1, high when t=63 and rnd_valid is high.
REQ-014 SHALL have port blk_done, output, 1, one-cycle pulse after round 63 is consumed.
REQ-015 SHALL have port abort, input, 1, synchronous abandon of the current block.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-017 In IDLE, the block SHALL assert blk_ready; when blk_valid and blk_ready are both high, it SHALL capture blk_data into an internal 512-bit register, set t=0 and go to RUN.
REQ-018 In RUN, the block SHALL assert rnd_valid continuously and blk_ready SHALL be low.
REQ-019 A round SHALL advance only on a cycle with rnd_valid and rnd_ready high; without rnd_ready, rnd_idx, rnd_w, rnd_first and rnd_last SHALL hold stable.
REQ-020 For t<16, rnd_w SHALL equal captured word t.
REQ-021 For t>=16, rnd_w SHALL equal W[t-16] + s0(W[t-15]) + W[t-7] + s1(W[t-2]) mod 2^32.
REQ-022 s0(x) SHALL be ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
REQ-023 s1(x) SHALL be ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
REQ-024 The block SHALL keep the previous words in a 16-entry x 32-bit ring buffer; on each round handshake, it SHALL write W_t into slot t mod 16 and read W[t-k] from slot (t-k) mod 16, with 4-bit wrap-around.
REQ-025 rnd_w SHALL be combinational from the ring buffer and the captured block, so round latency is zero after entry to RUN.
REQ-026 The first rnd_valid SHALL appear the cycle after block acceptance.
REQ-027 On the round-63 handshake, the block SHALL go to DONE and rnd_valid SHALL drop the next cycle.
REQ-028 In DONE, the block SHALL assert blk_done for exactly one cycle and also assert blk_ready.
REQ-029 If a block is accepted in DONE, the block SHALL go directly to RUN with t=0, giving back-to-back blocks a one-cycle gap.
REQ-030 Otherwise, DONE SHALL go to IDLE.
REQ-031 An abort in any state SHALL force IDLE and t=0 on the next edge, with no blk_done pulse.
REQ-032 abort SHALL take priority over both handshakes in the same cycle.
REQ-033 The ring buffer SHALL NOT need clearing on abort, because words 0..15 are rewritten before they are read.
REQ-034 blk_valid while blk_ready is low SHALL be ignored, and blk_data SHALL NOT be sampled.
REQ-035 rnd_ready while rnd_valid is low SHALL be ignored.

Reset
REQ-036 On rst_n low, asynchronously: state SHALL be IDLE, t=0, and rnd_valid, rnd_first, rnd_last and blk_done SHALL be 0.
REQ-037 On rst_n low, rnd_idx and rnd_w SHALL be 0, blk_ready SHALL be 0 while rst_n is low, and the captured block SHALL be 0.
REQ-038 Reset mid-RUN SHALL abandon the block with no blk_done pulse.
REQ-039 After rst_n deasserts, the block SHALL assert blk_ready at the first edge in IDLE.

Verification
REQ-040 Bench: "abc" padded block (word0=0x61626380, word15=0x00000018, others 0) with rnd_ready=1 -> rnd_w at t=0 is 0x61626380, t=15 is 0x00000018, t=16 is 0x61626380, t=17 is 0x000F0000; blk_done occurs 65 cycles after acceptance.
REQ-041 Bench: rnd_ready toggles randomly during "abc" -> the 64 rnd_w values are identical to REQ-040's, outputs hold while stalled, and exactly one rnd_first and one rnd_last occur.
REQ-042 Bench: two blocks offered back-to-back with blk_valid held -> second block accepted in the DONE cycle, rnd_first one cycle after blk_done, and second-block W values are correct.
REQ-043 Bench: abort at t=30, then a new block -> no blk_done, IDLE is entered, and the new block's W_16..W_63 match the reference model, showing no stale ring data.
REQ-044 Bench: rst_n asserted at t=40 -> all outputs are 0 immediately, and after release blk_ready=1 and no blk_done pulse occurs.
REQ-045 Bench: blk_valid pulsed during RUN with different data -> the pulse is ignored and the schedule is unchanged.
